// File: rtl/clock_div_pkg.sv
// Shared constants and the default high-time rule for the multi-channel clock divider.
package clock_div_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIV   = 10000;
    localparam int MAX_CH    = 16;
    localparam int MAX_WIDTH = 32;

    // Default high time: half the divisor, odd divisors give the spare cycle to the low phase.
    function automatic logic [MAX_WIDTH-1:0] hi_of(input logic [MAX_WIDTH-1:0] div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: period counter, active/pending divisor (and high time when
// CLK_DIV_DUTY_EN is defined), registered clk_out/tick/pend.
module clock_div_ch
    import clock_div_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_div,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0] cfg_hi,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] HI_RST  = WIDTH'(hi_of(MAX_WIDTH'(DEFAULT_DIV)));

    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] div_eff;
    logic [WIDTH-1:0] hi_eff;
    logic [WIDTH-1:0] hi_run;
    logic [WIDTH-1:0] cnt_p0;
    logic [WIDTH-1:0] k_next;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] h_next;
    logic             vld_p0;
    logic             run_p0;
    logic             pend_r;
    logic             clk_out_p1;
    logic             tick_p1;
    logic             boundary;
    logic             apply;
    logic             cont;
    logic             start;
    logic             go;
`ifdef CLK_DIV_DUTY_EN
    logic [WIDTH-1:0] hi_a;
    logic [WIDTH-1:0] hi_n;
`endif

    function automatic logic in_high(input logic [WIDTH-1:0] k,
                                     input logic [WIDTH-1:0] h,
                                     input logic [WIDTH-1:0] d);
        return ({1'b0, k} + {1'b0, h}) >= {1'b0, d};
    endfunction

    always_comb begin
        boundary = run_p0 && (cnt_p0 >= div_a - ONE);
        // Pending values land at a period boundary, or at once while the channel is idle.
        apply    = pend_r && (boundary || !en || (div_a == '0));
        div_eff  = apply ? div_n : div_a;
`ifdef CLK_DIV_DUTY_EN
        hi_eff   = apply ? hi_n : hi_a;
        hi_run   = hi_a;
`else
        hi_eff   = WIDTH'(hi_of(MAX_WIDTH'(div_eff)));
        hi_run   = WIDTH'(hi_of(MAX_WIDTH'(div_a)));
`endif
        cont     = vld_p0 && run_p0 && !boundary;
        start    = vld_p0 && !cont && (div_eff != '0);
        go       = cont || start;
        k_next   = '0;
        d_next   = div_eff;
        h_next   = hi_eff;
        if (cont) begin
            k_next = cnt_p0 + ONE;
            d_next = div_a;
            h_next = hi_run;
        end
    end

    // p0: registered enable and period index; p1: output flops for the index being shown
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0     <= 1'b0;
            run_p0     <= 1'b0;
            cnt_p0     <= '0;
            clk_out_p1 <= 1'b0;
            tick_p1    <= 1'b0;
            pend_r     <= 1'b0;
            div_a      <= DIV_RST;
            div_n      <= DIV_RST;
`ifdef CLK_DIV_DUTY_EN
            hi_a       <= HI_RST;
            hi_n       <= HI_RST;
`endif
        end else begin
            vld_p0     <= en;
            run_p0     <= go;
            cnt_p0     <= go ? k_next : '0;
            clk_out_p1 <= go && in_high(k_next, h_next, d_next);
            tick_p1    <= go && (k_next == d_next - ONE);
            if (apply) begin
                div_a  <= div_n;
`ifdef CLK_DIV_DUTY_EN
                hi_a   <= hi_n;
`endif
                pend_r <= 1'b0;
            end
            // A write in the apply cycle stays pending for the following boundary.
            if (cfg_we) begin
                div_n  <= cfg_div;
`ifdef CLK_DIV_DUTY_EN
                hi_n   <= cfg_hi;
`endif
                pend_r <= 1'b1;
            end
        end
    end

    assign clk_out = clk_out_p1;
    assign tick    = tick_p1;
    assign pend    = pend_r;

`ifndef CLK_DIV_DUTY_EN
    logic unused_hi_rst;
    assign unused_hi_rst = ^HI_RST;
`endif

endmodule

// File: rtl/clock_divide_multi.sv
// NUM_CH independent clock-divider channels sharing one config write port.
// CLK_DIV_DUTY_EN adds the cfg_hi port for a programmable high time.
module clock_divide_multi
    import clock_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0]  cfg_hi,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    logic [NUM_CH-1:0] ch_we;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Channel numbers at or above NUM_CH match no instance, so such writes vanish.
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        clock_div_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .cfg_we  (ch_we[i]),
            .cfg_div (cfg_div),
`ifdef CLK_DIV_DUTY_EN
            .cfg_hi  (cfg_hi),
`endif
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: tb/tb_clock_divide_multi.sv
// Bench for clock_divide_multi: per-cycle expected outputs queued from the period
// definition and compared as the DUT produces them. Duty scenario under CLK_DIV_DUTY_EN.
module tb_clock_divide_multi;

    localparam int NCH = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  en;
    logic            cfg_we;
    logic [1:0]      cfg_ch;
    logic [15:0]     cfg_div;
`ifdef CLK_DIV_DUTY_EN
    logic [15:0]     cfg_hi;
`endif
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  pend;

    typedef struct packed {
        logic [2:0] c;
        logic [2:0] t;
        logic [2:0] p;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    clock_divide_multi #(
        .NUM_CH      (NCH),
        .WIDTH       (16),
        .DEFAULT_DIV (10000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
`ifdef CLK_DIV_DUTY_EN
        .cfg_hi  (cfg_hi),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Channel 0 waveform for n cycles of a running divider starting at k=0.
    function automatic void push_run(int div, int hi, int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            int k;
            k   = j % div;
            e.c = {2'b00, (k + hi >= div)};
            e.t = {2'b00, (k == div - 1)};
            e.p = 3'b000;
            sb.push_back(e);
        end
    endfunction

    function automatic void push_const(logic [2:0] c, logic [2:0] t, logic [2:0] p, int n);
        exp_t e;
        e.c = c;
        e.t = t;
        e.p = p;
        for (int j = 0; j < n; j++) sb.push_back(e);
    endfunction

    function automatic void set_pend(int lo, int hi_idx, logic [2:0] m);
        exp_t e;
        for (int j = lo; j <= hi_idx; j++) begin
            e      = sb[j];
            e.p    = e.p | m;
            sb[j]  = e;
        end
    endfunction

    task automatic cfg_write(int ch, int div);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = 16'(div);
`ifdef CLK_DIV_DUTY_EN
        cfg_hi  = 16'(div >> 1);
`endif
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        push_const(3'b000, 3'b000, 3'b000, 3);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL reset cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
        end
    endtask

    task automatic test_default();
        exp_t e;
        int   n;
        rst = 1'b1;
        en  = 3'b001;
        push_const(3'b000, 3'b000, 3'b000, 1);
        push_run(10000, 5000, 20000);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL default cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
        end
    endtask

    task automatic test_write_mid();
        exp_t e;
        int   n;
        push_run(10000, 5000, 10000);
        set_pend(3000, 9999, 3'b001);
        push_run(7, 3, 21);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL write_mid cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
            cfg_we = 1'b0;
            if (i == 2999) cfg_write(0, 7);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        push_run(7, 3, 7);
        set_pend(1, 6, 3'b001);
        push_run(9, 4, 18);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
            cfg_we = 1'b0;
            if (i == 0) cfg_write(0, 5);
            if (i == 2) cfg_write(0, 9);
        end
    endtask

    task automatic test_div_edges();
        exp_t e;
        int   n;
        push_run(9, 4, 9);
        set_pend(1, 8, 3'b001);
        push_const(3'b000, 3'b001, 3'b000, 5);
        push_const(3'b000, 3'b001, 3'b001, 1);
        push_const(3'b000, 3'b000, 3'b000, 5);
        push_const(3'b000, 3'b000, 3'b001, 1);
        push_run(4, 2, 8);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL div_edges cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
            cfg_we = 1'b0;
            if (i == 0)  cfg_write(0, 1);
            if (i == 13) cfg_write(0, 0);
            if (i == 19) cfg_write(0, 4);
        end
    endtask

    task automatic test_en_drop();
        exp_t e;
        int   n;
        push_const(3'b000, 3'b000, 3'b000, 1);
        push_const(3'b000, 3'b000, 3'b001, 1);
        push_const(3'b001, 3'b000, 3'b000, 1);
        push_const(3'b000, 3'b000, 3'b000, 5);
        push_run(3, 1, 6);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL en_drop cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
            cfg_we = 1'b0;
            if (i == 0) cfg_write(0, 3);
            if (i == 1) en = 3'b000;
            if (i == 6) en = 3'b001;
        end
    endtask

    task automatic test_channels();
        exp_t e;
        int   n;
        push_run(3, 1, 12);
        set_pend(4, 4, 3'b010);
        // channel 1 runs div=5 (low 3, high 2) for one period at entries 7..11
        for (int k = 0; k < 5; k++) begin
            e       = sb[7 + k];
            e.c[1]  = (k >= 3);
            e.t[1]  = (k == 4);
            sb[7 + k] = e;
        end
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL channels cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
            cfg_we = 1'b0;
            if (i == 0)  cfg_write(3, 2);
            if (i == 3)  cfg_write(1, 5);
            if (i == 5)  en = 3'b011;
            if (i == 10) en = 3'b001;
        end
    endtask

`ifdef CLK_DIV_DUTY_EN
    task automatic test_duty();
        exp_t e;
        int   n;
        push_run(3, 1, 3);
        set_pend(1, 2, 3'b001);
        push_run(10, 3, 10);
        set_pend(4, 12, 3'b001);
        push_run(10, 12, 10);
        set_pend(14, 22, 3'b001);
        push_run(3, 1, 3);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL duty cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
            cfg_we = 1'b0;
            if (i == 0) begin
                cfg_write(0, 10);
                cfg_hi = 16'd3;
            end
            if (i == 3) begin
                cfg_write(0, 10);
                cfg_hi = 16'd12;
            end
            if (i == 13) cfg_write(0, 3);
        end
    endtask
`endif

    task automatic test_reset_mid();
        exp_t e;
        int   n;
        push_const(3'b000, 3'b000, 3'b000, 1);
        push_const(3'b000, 3'b000, 3'b001, 1);
        push_const(3'b000, 3'b000, 3'b000, 3);
        push_run(10000, 5000, 5001);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            cycle();
            e = sb.pop_front();
            total++;
            if ({clk_out, tick, pend} !== {e.c, e.t, e.p}) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got clk_out=%b tick=%b pend=%b want %b %b %b",
                         i, clk_out, tick, pend, e.c, e.t, e.p);
            end
            cfg_we = 1'b0;
            if (i == 0) cfg_write(0, 7);
            if (i == 1) rst = 1'b0;
            if (i == 3) rst = 1'b1;
        end
    endtask

    initial begin
        rst     = 1'b0;
        en      = '0;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;
`ifdef CLK_DIV_DUTY_EN
        cfg_hi  = '0;
`endif
        test_reset();
        test_default();
        test_write_mid();
        test_back_to_back();
        test_div_edges();
        test_en_drop();
        test_channels();
`ifdef CLK_DIV_DUTY_EN
        test_duty();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_divide_multi.md
# clock_divide_multi

Parametrised multi-channel clock divider producing glitch-free square-wave enables and one-cycle period ticks from the single system clock. Each channel has a runtime-programmable divisor, optional programmable high time, and a per-channel enable. Channel 0 replaces the fixed 500 Hz display-scan divider. Further channels serve the 1 Hz countdown tick and the buzzer tone, so no hard-coded dividers are needed.

## Interface
- `NUM_CH`, 2: number of independent channels (1..16).
- `WIDTH`, 16: divisor/counter width in bits.
- `DEFAULT_DIV`, 10000: divisor loaded into every channel at reset (must be < 2^WIDTH).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  NUM_CH  per-channel run enable.
- `cfg_we`  in  1  config write strobe, one cycle.
- `cfg_ch`  in  max(1,$clog2(NUM_CH))  target channel of write.
- `cfg_div`  in  WIDTH  new divisor.
- `cfg_hi`  in  WIDTH  new high time in cycles; present only with CLK_DIV_DUTY_EN.
- `clk_out`  out  NUM_CH  divided square wave, registered.
- `tick`  out  NUM_CH  one-cycle pulse on the last cycle of each period, registered.
- `pend`  out  NUM_CH  config written but not yet applied.

## Operation
- Reset (`rst`=0 at a clock edge): every channel div=DEFAULT_DIV, hi=DEFAULT_DIV>>1, counter 0, pending cleared; `clk_out`, `tick`, `pend` all 0.
- Period index k runs 0..div-1. Index 0 is the first cycle `clk_out`/`tick` reflect after the channel starts (reset release with `en`=1, or `en` rising).
- `clk_out[i]` = 1 for k ≥ div−hi, otherwise 0. The low phase comes first. Odd div with default hi gives the extra cycle to low.
- `tick[i]` = 1 only at k = div−1.
- Config write: `cfg_we`=1 latches cfg_div (and cfg_hi) into channel `cfg_ch`'s pending register and sets `pend`. A second write before apply overwrites the pending values. cfg_ch ≥ NUM_CH: write ignored.
- Apply: pending values take effect at the period boundary (the k=0 after the current k=div−1), then `pend` clears. An active period is never truncated or stretched.
- `en[i]`=0: counter held at 0, `clk_out`/`tick` 0. Any pending value applies immediately and `pend` clears the next cycle.
- div=0: channel stopped, outputs 0, as if disabled; a later nonzero write applies immediately.
- div=1: `tick` constantly 1. `clk_out` is 0 for hi=0, 1 for hi≥1.
- hi ≥ div: `clk_out` constantly 1. hi=0: constantly 0.
- Write and apply boundary in the same cycle: the boundary applies the old pending values; the new write becomes pending.
- Reset mid-operation overrides everything, including pending writes.

## Timing
- All outputs are flops; no combinational path from inputs to outputs.
- `cfg_we` at edge n: `pend` is 1 after edge n. The new divisor governs the period starting at the next boundary.
- `en` rising at edge n: k=0 is visible after edge n+1. `en` falling at edge n: outputs are 0 after edge n+1.
- Throughput: one config write per cycle.

## Configuration
- `CLK_DIV_DUTY_EN` defined: `cfg_hi` port and per-channel hi/pending-hi registers exist; high time is programmable.
- Not defined: no `cfg_hi` port. hi is always derived as div>>1, recomputed whenever div is applied.

## Structure
- Package `clock_div_pkg`: default WIDTH, DEFAULT_DIV, max channel count, and the hi-derivation function (div>>1).
- Sub-module `clock_div_ch`: one channel holding counter, active/pending registers and output flops. The top instantiates `NUM_CH` copies and decodes `cfg_we`/`cfg_ch`.

## Test plan
- Reset, defaults, `en`=1 → `clk_out[0]` low 5000 cycles, high 5000; `tick[0]` once per 10000 cycles at the last high cycle.
- Write div=7 mid-period → current period completes at 10000 cycles and `pend`=1 throughout. The next period is low 4, high 3, and `pend` clears.
- Two writes (div=5, then div=9) before the boundary → only div=9 applied; divisor 5 is never seen.
- div=1 → `tick` constantly 1, `clk_out` 0. div=0 → all outputs 0. Then div=4 → restarts with low 2, high 2.
- `en` drop with pending div=3 → outputs 0 next cycle, `pend` clears. Re-enable → period of 3 cycles.
- With `CLK_DIV_DUTY_EN`: div=10, hi=3 → low 7, high 3; hi=12 → constant high. `rst`=0 mid-period → all outputs 0, defaults restored.
